// File: rtl/qformat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qformat_pkg
//  Description : Shared Q-format constants, saturating add helper and the
//                accumulator state encoding for the Kalman datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package qformat_pkg;

    localparam int Q = 18;
    localparam int N = 32;

    localparam logic [N-1:0] QMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] QMIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    // Returns {sum, sat}; sat is set when the result had to be clamped.
    function automatic logic [N:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] raw;
        logic         sat;
        raw = a + b;
        sat = (a[N-1] == b[N-1]) && (raw[N-1] != a[N-1]);
        if (sat) begin
            raw = a[N-1] ? QMIN : QMAX;
        end
        return {raw, sat};
    endfunction

endpackage
`default_nettype wire

// File: rtl/qmac_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : qmac_accumulator_if
//  Description : Product-in / sum-out valid/ready bundle of the Q-format
//                accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface qmac_accumulator_if #(
    parameter int N         = 32,
    parameter int MAX_TERMS = 8
);
    localparam int CW = $clog2(MAX_TERMS + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_ovr;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_ovr;
    logic [CW-1:0] out_count;

    modport master (
        output in_valid, in_data, in_ovr, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovr, out_count
    );

    modport slave (
        input  in_valid, in_data, in_ovr, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovr, out_count
    );
endinterface
`default_nettype wire

// File: rtl/qsat_add.sv
`default_nettype none
// ============================================================================
//  Module      : qsat_add
//  Description : Combinational two's-complement saturating adder of
//                parameterised width; reports whether it clamped.
//  Revision    : 1.0 - initial release
// ============================================================================
module qsat_add #(
    parameter int W = 32
) (
    input  wire logic [W-1:0] i_a,
    input  wire logic [W-1:0] i_b,
    output logic      [W-1:0] o_sum,
    output logic              o_sat
);
    logic [W-1:0] w_raw;

    assign w_raw = i_a + i_b;
    assign o_sat = (i_a[W-1] == i_b[W-1]) && (w_raw[W-1] != i_a[W-1]);

    always_comb begin
        o_sum = w_raw;
        if (o_sat) begin
            o_sum = i_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
endmodule
`default_nettype wire

// File: rtl/qmac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : qmac_accumulator
//  Description : Sums a stream of Q-format products into one dot-product term
//                with sticky overflow, delivered over valid/ready.
//                Optional macro QMAC_GUARD_BITS_EN: wide accumulator with a
//                single saturation when the sum closes.
//  Revision    : 1.0 - initial release
// ============================================================================
module qmac_accumulator
    import qformat_pkg::*;
#(
    parameter int Q         = qformat_pkg::Q,
    parameter int N         = qformat_pkg::N,
    parameter int MAX_TERMS = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    qmac_accumulator_if.slave bus
);
    localparam int CW = $clog2(MAX_TERMS + 1);
`ifdef QMAC_GUARD_BITS_EN
    localparam int ACC_W = N + $clog2(MAX_TERMS);
`else
    localparam int ACC_W = N;
`endif

    localparam logic [0:0]    c_ST_ACC  = ST_ACC;
    localparam logic [0:0]    c_ST_DONE = ST_DONE;
    localparam logic [N-1:0]  c_QMAX    = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  c_QMIN    = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] c_MAX_CNT = CW'(MAX_TERMS);

    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("qmac_accumulator: Q must lie in [0, N)");
    end

    logic [0:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovr;
    logic [CW-1:0]    r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [N-1:0]     r_out_data;
    logic             r_out_ovr;
    logic [CW-1:0]    r_out_count;

    logic [ACC_W-1:0] w_term;
    logic [ACC_W-1:0] w_add_sum;
    logic             w_add_sat;
    logic [N-1:0]     w_close_data;
    logic             w_close_sat;
    logic [CW-1:0]    w_count_inc;
    logic             w_accept;
    logic             w_close;

    qsat_add #(.W(ACC_W)) u_add (
        .i_a   (r_acc),
        .i_b   (w_term),
        .o_sum (w_add_sum),
        .o_sat (w_add_sat)
    );

`ifdef QMAC_GUARD_BITS_EN
    // Guard bits cover MAX_TERMS full-scale products, so the wide add never
    // clamps; the only saturation happens once when narrowing the result.
    logic [ACC_W-N:0] w_hi;

    assign w_term = {{(ACC_W-N){bus.in_data[N-1]}}, bus.in_data};
    assign w_hi   = w_add_sum[ACC_W-1:N-1];

    always_comb begin
        w_close_sat  = !((&w_hi) || !(|w_hi));
        w_close_data = w_add_sum[N-1:0];
        if (w_close_sat) begin
            w_close_data = w_add_sum[ACC_W-1] ? c_QMIN : c_QMAX;
        end
    end
`else
    assign w_term       = bus.in_data;
    assign w_close_data = w_add_sum;
    assign w_close_sat  = 1'b0;
`endif

    assign w_count_inc = r_count + 1'b1;
    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_close     = bus.in_last || (w_count_inc == c_MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_ACC;
            r_acc       <= '0;
            r_ovr       <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovr   <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                c_ST_ACC: begin
                    if (w_accept) begin
                        if (w_close) begin
                            r_state     <= c_ST_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_close_data;
                            r_out_ovr   <= r_ovr | bus.in_ovr | w_add_sat | w_close_sat;
                            r_out_count <= w_count_inc;
                        end else begin
                            r_acc   <= w_add_sum;
                            r_ovr   <= r_ovr | bus.in_ovr | w_add_sat;
                            r_count <= w_count_inc;
                        end
                    end
                end
                c_ST_DONE: begin
                    // No bypass: the next sum can only start after this cycle.
                    if (bus.out_ready) begin
                        r_state     <= c_ST_ACC;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_ovr       <= 1'b0;
                        r_count     <= '0;
                    end
                end
                default: r_state <= c_ST_ACC;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovr   = r_out_ovr;
    assign bus.out_count = r_out_count;
endmodule
`default_nettype wire

// File: tb/tb_qmac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qmac_accumulator
//  Description : Directed self-checking bench for qmac_accumulator
//                (MAX_TERMS=8 and MAX_TERMS=4 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qmac_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    qmac_accumulator_if #(.N(32), .MAX_TERMS(8)) b8 ();
    qmac_accumulator_if #(.N(32), .MAX_TERMS(4)) b4 ();

    qmac_accumulator #(.Q(18), .N(32), .MAX_TERMS(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));
    qmac_accumulator #(.Q(18), .N(32), .MAX_TERMS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one term on the 8-term DUT and returns #1 after it is accepted.
    task automatic send8(input logic [31:0] d, input logic o, input logic l);
        int n = 0;
        @(negedge clk);
        b8.in_valid = 1'b1; b8.in_data = d; b8.in_ovr = o; b8.in_last = l;
        while (!b8.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send8 in_ready timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0; b8.in_ovr = 1'b0; b8.in_last = 1'b0;
    endtask

    task automatic send4(input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        b4.in_valid = 1'b1; b4.in_data = d; b4.in_ovr = 1'b0; b4.in_last = 1'b0;
        while (!b4.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send4 in_ready timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        b4.in_valid = 1'b0;
    endtask

    task automatic result8(input string tag, input logic [31:0] d, input logic o, input logic [3:0] c);
        chk({tag, " out_valid"}, 64'(b8.out_valid), 64'd1);
        chk({tag, " out_data"},  64'(b8.out_data),  64'(d));
        chk({tag, " out_ovr"},   64'(b8.out_ovr),   64'(o));
        chk({tag, " out_count"}, 64'(b8.out_count), 64'(c));
    endtask

    task automatic take8();
        @(negedge clk);
        b8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b8.out_ready = 1'b0;
        chk("take8 out_valid drop", 64'(b8.out_valid), 64'd0);
        chk("take8 in_ready back", 64'(b8.in_ready), 64'd1);
    endtask

    task automatic take4();
        @(negedge clk);
        b4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b4.out_ready = 1'b0;
    endtask

    initial begin
        b8.in_valid = 0; b8.in_data = '0; b8.in_ovr = 0; b8.in_last = 0; b8.out_ready = 0;
        b4.in_valid = 0; b4.in_data = '0; b4.in_ovr = 0; b4.in_last = 0; b4.out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset out_valid", 64'(b8.out_valid), 64'd0);
        chk("reset out_data",  64'(b8.out_data),  64'd0);
        chk("reset out_ovr",   64'(b8.out_ovr),   64'd0);
        chk("reset out_count", 64'(b8.out_count), 64'd0);
        chk("reset in_ready",  64'(b8.in_ready),  64'd1);

        // 1.0 + 2.0 - 0.5 = 2.5
        send8(32'h0004_0000, 1'b0, 1'b0);
        send8(32'h0008_0000, 1'b0, 1'b0);
        send8(32'hFFFE_0000, 1'b0, 1'b1);
        result8("basic", 32'h000A_0000, 1'b0, 4'd3);
        chk("basic in_ready", 64'(b8.in_ready), 64'd0);

        // Held result: inputs ignored, outputs frozen
        @(negedge clk);
        b8.in_valid = 1'b1; b8.in_data = 32'h0001_2345; b8.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold out_data", 64'(b8.out_data), 64'h000A_0000);
            chk("hold in_ready", 64'(b8.in_ready), 64'd0);
        end
        result8("hold", 32'h000A_0000, 1'b0, 4'd3);
        b8.in_valid = 1'b0; b8.in_last = 1'b0;
        take8();
        send8(32'h0004_0000, 1'b0, 1'b1);
        result8("after hold", 32'h0004_0000, 1'b0, 4'd1);
        take8();

        // Saturation path
        send8(32'h7FFF_0000, 1'b0, 1'b0);
        send8(32'h0002_0000, 1'b0, 1'b0);
        send8(32'hFFFC_0000, 1'b0, 1'b1);
`ifdef QMAC_GUARD_BITS_EN
        result8("sat", 32'h7FFD_0000, 1'b0, 4'd3);
`else
        result8("sat", 32'h7FFB_FFFF, 1'b1, 4'd3);
`endif
        take8();

        // Multiplier overflow flag is sticky for one sum only
        send8(32'h0004_0000, 1'b0, 1'b0);
        send8(32'h0004_0000, 1'b1, 1'b0);
        send8(32'h0004_0000, 1'b0, 1'b1);
        result8("in_ovr", 32'h000C_0000, 1'b1, 4'd3);
        take8();
        send8(32'h0004_0000, 1'b0, 1'b0);
        send8(32'hFFFC_0000, 1'b0, 1'b1);
        result8("clean", 32'h0000_0000, 1'b0, 4'd2);
        take8();

        // Auto-close at MAX_TERMS=4
        for (int i = 0; i < 8; i++) begin
            send4(32'h0004_0000);
            if (i % 4 == 3) begin
                chk("auto out_valid", 64'(b4.out_valid), 64'd1);
                chk("auto out_data",  64'(b4.out_data),  64'h0010_0000);
                chk("auto out_count", 64'(b4.out_count), 64'd4);
                chk("auto out_ovr",   64'(b4.out_ovr),   64'd0);
                take4();
            end else begin
                chk("auto no result", 64'(b4.out_valid), 64'd0);
            end
        end

        // Reset in the middle of a sum
        send8(32'h0004_0000, 1'b0, 1'b0);
        send8(32'h0004_0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst out_valid", 64'(b8.out_valid), 64'd0);
        chk("midrst out_data",  64'(b8.out_data),  64'd0);
        chk("midrst out_ovr",   64'(b8.out_ovr),   64'd0);
        chk("midrst out_count", 64'(b8.out_count), 64'd0);
        chk("midrst in_ready",  64'(b8.in_ready),  64'd1);
        send8(32'h0004_0000, 1'b0, 1'b1);
        result8("post rst", 32'h0004_0000, 1'b0, 4'd1);
        take8();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
